set_mode_controller: RTL and testbench



---
 rtl/clock_pkg.sv | 59 +++++
 rtl/set_mode_controller_if.sv | 22 ++
 rtl/button_press.sv | 25 ++
 rtl/set_mode_controller.sv | 116 +++++++++++
 tb/tb_set_mode_controller.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the 7-segment clock: edit-mode states, blink selects
// and the counter strobe bundle.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } set_state_t;

  localparam logic [2:0] BLINK_NONE    = 3'b000;
  localparam logic [2:0] BLINK_HOURS   = 3'b100;
  localparam logic [2:0] BLINK_MINUTES = 3'b010;
  localparam logic [2:0] BLINK_SECONDS = 3'b001;

  typedef struct packed {
    logic inc_hours;
    logic inc_minutes;
    logic clr_seconds;
  } strobe_t;

  // MODE cycles RUN -> SET_H -> SET_M -> SET_S -> RUN
  function automatic set_state_t mode_next(input set_state_t s);
    set_state_t n;
    case (s)
      ST_RUN:   n = ST_SET_H;
      ST_SET_H: n = ST_SET_M;
      ST_SET_M: n = ST_SET_S;
      default:  n = ST_RUN;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] blink_sel(input set_state_t s);
    logic [2:0] b;
    case (s)
      ST_SET_H: b = BLINK_HOURS;
      ST_SET_M: b = BLINK_MINUTES;
      ST_SET_S: b = BLINK_SECONDS;
      default:  b = BLINK_NONE;
    endcase
    return b;
  endfunction

  // Strobe that an INC action produces in a given state
  function automatic strobe_t strobe_sel(input set_state_t s);
    strobe_t st;
    st = '0;
    case (s)
      ST_SET_H: st.inc_hours   = 1'b1;
      ST_SET_M: st.inc_minutes = 1'b1;
      ST_SET_S: st.clr_seconds = 1'b1;
      default:  st = '0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/set_mode_controller_if.sv
// Button/tick inputs and blink/strobe outputs of the time-setting controller.
interface set_mode_controller_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       tick_sec;
  logic       tick_rep;
  logic [2:0] blink_control;
  logic       inc_hours;
  logic       inc_minutes;
  logic       clr_seconds;
  logic       run_en;

  modport master (
    output btn_mode, btn_inc, tick_sec, tick_rep,
    input  blink_control, inc_hours, inc_minutes, clr_seconds, run_en
  );

  modport slave (
    input  btn_mode, btn_inc, tick_sec, tick_rep,
    output blink_control, inc_hours, inc_minutes, clr_seconds, run_en
  );
endinterface

// File: rtl/button_press.sv
// Debounced level to one-cycle registered press pulse; after reset the button
// must be seen low once before a rising edge counts.
module button_press (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic press
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      prev_q <= level;
      if (!level) armed_q <= 1'b1;
      press <= armed_q & level & ~prev_q;
    end
  end

endmodule

// File: rtl/set_mode_controller.sv
// Edit-mode FSM for the clock: selects the digit pair being set, issues
// increment/clear strobes, auto-repeats held INC and times out back to RUN.
module set_mode_controller
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = 30,
  parameter int unsigned HOLD_S    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  set_mode_controller_if.slave  bus
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_S + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_S + 1);

  logic mode_p;
  logic inc_p;

  button_press u_mode_press (
    .clk   (clk),
    .rst_n (rst_n),
    .level (bus.btn_mode),
    .press (mode_p)
  );

  button_press u_inc_press (
    .clk   (clk),
    .rst_n (rst_n),
    .level (bus.btn_inc),
    .press (inc_p)
  );

  set_state_t        state_q, state_nxt;
  logic [IDLE_W-1:0] idle_q, idle_nxt;
  logic [HOLD_W-1:0] hold_q, hold_nxt;
  logic              rep_ok_q, rep_ok_nxt;
  logic              rep_q;
  strobe_t           stb_q, stb_nxt;
  logic [2:0]        blink_q;
  logic              run_en_q;

  logic timeout;
  logic hold_sat;
  logic state_chg;
  logic rep_state;

  // Next state, strobes and counter updates; at most one strobe per cycle
  always_comb begin
    state_nxt  = state_q;
    stb_nxt    = '0;
    idle_nxt   = idle_q;
    hold_nxt   = hold_q;
    rep_ok_nxt = rep_ok_q;

    timeout   = (state_q != ST_RUN) && (idle_q == IDLE_W'(TIMEOUT_S));
    hold_sat  = (hold_q == HOLD_W'(HOLD_S));
    rep_state = (state_q == ST_SET_H) || (state_q == ST_SET_M);

    if (mode_p) begin
      state_nxt = mode_next(state_q);
    end else if (inc_p) begin
      stb_nxt = strobe_sel(state_q);
    end else if (timeout) begin
      state_nxt = ST_RUN;
    end else if (rep_q && hold_sat && rep_ok_q && rep_state) begin
      stb_nxt = strobe_sel(state_q);
    end

    state_chg = (state_nxt != state_q);

    if (mode_p || inc_p || bus.btn_inc || state_chg || (state_q == ST_RUN)) begin
      idle_nxt = '0;
    end else if (bus.tick_sec && !timeout) begin
      idle_nxt = idle_q + IDLE_W'(1);
    end

    // Repeat needs a fresh INC press in the current state
    if (!bus.btn_inc || state_chg) begin
      hold_nxt   = '0;
      rep_ok_nxt = 1'b0;
    end else begin
      if (bus.tick_sec && !hold_sat) hold_nxt = hold_q + HOLD_W'(1);
      if (inc_p) rep_ok_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      idle_q   <= '0;
      hold_q   <= '0;
      rep_ok_q <= 1'b0;
      rep_q    <= 1'b0;
      stb_q    <= '0;
      blink_q  <= BLINK_NONE;
      run_en_q <= 1'b1;
    end else begin
      state_q  <= state_nxt;
      idle_q   <= idle_nxt;
      hold_q   <= hold_nxt;
      rep_ok_q <= rep_ok_nxt;
      rep_q    <= bus.tick_rep;
      stb_q    <= stb_nxt;
      blink_q  <= blink_sel(state_nxt);
      run_en_q <= (state_nxt != ST_SET_S);
    end
  end

  assign bus.blink_control = blink_q;
  assign bus.inc_hours     = stb_q.inc_hours;
  assign bus.inc_minutes   = stb_q.inc_minutes;
  assign bus.clr_seconds   = stb_q.clr_seconds;
  assign bus.run_en        = run_en_q;

endmodule

// File: tb/tb_set_mode_controller.sv
// Directed bench for set_mode_controller: per-cycle vector table plus
// sequences for timeout, auto-repeat and reset-while-held behaviour.
module tb_set_mode_controller;

  logic clk;
  logic rst_n;

  set_mode_controller_if bus ();

  set_mode_controller #(
    .TIMEOUT_S (30),
    .HOLD_S    (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic       i;
    logic [2:0] blink;
    logic       run;
    logic       h;
    logic       mi;
    logic       c;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cnt_h = 0;
  int   cnt_m = 0;
  int   cnt_c = 0;

  always @(negedge clk) begin
    if (bus.inc_hours)   cnt_h++;
    if (bus.inc_minutes) cnt_m++;
    if (bus.clr_seconds) cnt_c++;
  end

  function automatic vec_t v(input logic m, input logic i, input logic [2:0] b,
                             input logic r, input logic h, input logic mi, input logic c);
    vec_t x;
    x.m = m; x.i = i; x.blink = b; x.run = r; x.h = h; x.mi = mi; x.c = c;
    return x;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int h0, m0, c0;

  initial begin
    rst_n        = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.tick_sec = 1'b0;
    bus.tick_rep = 1'b0;

    // rows: mode, inc -> blink, run_en, inc_hours, inc_minutes, clr_seconds
    tbl.push_back(v(0,0,3'b000,1,0,0,0)); // 0
    tbl.push_back(v(1,0,3'b000,1,0,0,0));
    tbl.push_back(v(0,0,3'b000,1,0,0,0));
    tbl.push_back(v(1,0,3'b100,1,0,0,0));
    tbl.push_back(v(0,0,3'b100,1,0,0,0));
    tbl.push_back(v(1,0,3'b010,1,0,0,0)); // 5
    tbl.push_back(v(0,0,3'b010,1,0,0,0));
    tbl.push_back(v(1,0,3'b001,0,0,0,0));
    tbl.push_back(v(0,0,3'b001,0,0,0,0));
    tbl.push_back(v(0,0,3'b000,1,0,0,0));
    tbl.push_back(v(0,1,3'b000,1,0,0,0)); // 10: INC in RUN
    tbl.push_back(v(0,0,3'b000,1,0,0,0));
    tbl.push_back(v(0,0,3'b000,1,0,0,0));
    tbl.push_back(v(1,0,3'b000,1,0,0,0));
    tbl.push_back(v(0,0,3'b000,1,0,0,0));
    tbl.push_back(v(1,0,3'b100,1,0,0,0)); // 15
    tbl.push_back(v(0,0,3'b100,1,0,0,0));
    tbl.push_back(v(0,0,3'b010,1,0,0,0));
    tbl.push_back(v(0,1,3'b010,1,0,0,0));
    tbl.push_back(v(0,1,3'b010,1,0,0,0));
    tbl.push_back(v(0,0,3'b010,1,0,1,0)); // 20
    tbl.push_back(v(0,1,3'b010,1,0,0,0));
    tbl.push_back(v(0,0,3'b010,1,0,0,0));
    tbl.push_back(v(0,1,3'b010,1,0,1,0));
    tbl.push_back(v(0,0,3'b010,1,0,0,0));
    tbl.push_back(v(0,0,3'b010,1,0,1,0)); // 25
    tbl.push_back(v(0,0,3'b010,1,0,0,0));
    tbl.push_back(v(1,0,3'b010,1,0,0,0));
    tbl.push_back(v(0,0,3'b010,1,0,0,0));
    tbl.push_back(v(1,0,3'b001,0,0,0,0));
    tbl.push_back(v(0,0,3'b001,0,0,0,0)); // 30
    tbl.push_back(v(1,0,3'b000,1,0,0,0));
    tbl.push_back(v(0,0,3'b000,1,0,0,0));
    tbl.push_back(v(0,0,3'b100,1,0,0,0));
    tbl.push_back(v(1,1,3'b100,1,0,0,0)); // 34: MODE+INC together
    tbl.push_back(v(0,0,3'b100,1,0,0,0)); // 35
    tbl.push_back(v(0,0,3'b010,1,0,0,0));
    tbl.push_back(v(0,0,3'b010,1,0,0,0));
    tbl.push_back(v(1,0,3'b010,1,0,0,0));
    tbl.push_back(v(0,0,3'b010,1,0,0,0));
    tbl.push_back(v(0,1,3'b001,0,0,0,0)); // 40
    tbl.push_back(v(0,0,3'b001,0,0,0,0));
    tbl.push_back(v(0,0,3'b001,0,0,0,1));
    tbl.push_back(v(0,0,3'b001,0,0,0,0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset blink", int'(bus.blink_control), 0);
    chk("reset run_en", int'(bus.run_en), 1);
    chk("reset inc_hours", int'(bus.inc_hours), 0);
    chk("reset inc_minutes", int'(bus.inc_minutes), 0);
    chk("reset clr_seconds", int'(bus.clr_seconds), 0);
    cyc();
    rst_n = 1'b1;

    for (int n = 0; n < tbl.size(); n++) begin
      bus.btn_mode = tbl[n].m;
      bus.btn_inc  = tbl[n].i;
      @(negedge clk);
      chk($sformatf("row%0d blink", n), int'(bus.blink_control), int'(tbl[n].blink));
      chk($sformatf("row%0d run_en", n), int'(bus.run_en), int'(tbl[n].run));
      chk($sformatf("row%0d inc_hours", n), int'(bus.inc_hours), int'(tbl[n].h));
      chk($sformatf("row%0d inc_minutes", n), int'(bus.inc_minutes), int'(tbl[n].mi));
      chk($sformatf("row%0d clr_seconds", n), int'(bus.clr_seconds), int'(tbl[n].c));
      cyc();
    end

    // Idle timeout from SET_S after 30 seconds
    h0 = cnt_h; m0 = cnt_m; c0 = cnt_c;
    for (int t = 1; t <= 30; t++) begin
      bus.tick_sec = 1'b1;
      cyc();
      bus.tick_sec = 1'b0;
      if (t < 30) repeat (3) cyc();
    end
    @(negedge clk);
    chk("timeout not early blink", int'(bus.blink_control), 1);
    cyc();
    @(negedge clk);
    chk("timeout blink", int'(bus.blink_control), 0);
    chk("timeout run_en", int'(bus.run_en), 1);
    chk("timeout strobes", (cnt_h - h0) + (cnt_m - m0) + (cnt_c - c0), 0);

    // Auto-repeat in SET_H: 3 seconds held, 8 repeats per second
    bus.btn_mode = 1'b1; cyc();
    bus.btn_mode = 1'b0; repeat (3) cyc();
    h0 = cnt_h; m0 = cnt_m; c0 = cnt_c;
    bus.btn_inc = 1'b1;
    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < 8; r++) begin
        repeat (4) cyc();
        bus.tick_rep = 1'b1; cyc();
        bus.tick_rep = 1'b0;
      end
      repeat (2) cyc();
      bus.tick_sec = 1'b1; cyc();
      bus.tick_sec = 1'b0;
    end
    repeat (2) cyc();
    bus.btn_inc = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    chk("repeat inc_hours count", cnt_h - h0, 17);
    chk("repeat other strobes", (cnt_m - m0) + (cnt_c - c0), 0);
    chk("repeat blink", int'(bus.blink_control), 4);

    // MODE while INC held: no repeat in the new state
    h0 = cnt_h; m0 = cnt_m;
    cyc();
    bus.btn_inc = 1'b1; repeat (3) cyc();
    bus.btn_mode = 1'b1; cyc();
    bus.btn_mode = 1'b0; repeat (3) cyc();
    bus.tick_sec = 1'b1; cyc();
    bus.tick_sec = 1'b0;
    for (int r = 0; r < 4; r++) begin
      repeat (2) cyc();
      bus.tick_rep = 1'b1; cyc();
      bus.tick_rep = 1'b0;
    end
    repeat (3) cyc();
    @(negedge clk);
    chk("held-mode inc_hours", cnt_h - h0, 1);
    chk("held-mode inc_minutes", cnt_m - m0, 0);
    chk("held-mode blink", int'(bus.blink_control), 2);

    // Reset mid-edit with MODE and INC held through release
    cyc();
    h0 = cnt_h; m0 = cnt_m; c0 = cnt_c;
    bus.btn_mode = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async reset blink", int'(bus.blink_control), 0);
    chk("async reset run_en", int'(bus.run_en), 1);
    chk("async reset strobes", int'({bus.inc_hours, bus.inc_minutes, bus.clr_seconds}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) cyc();
    @(negedge clk);
    chk("held through reset blink", int'(bus.blink_control), 0);
    chk("held through reset strobes", (cnt_h - h0) + (cnt_m - m0) + (cnt_c - c0), 0);
    cyc();
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    repeat (2) cyc();
    bus.btn_mode = 1'b1; cyc();
    bus.btn_mode = 1'b0; repeat (3) cyc();
    @(negedge clk);
    chk("post-reset mode blink", int'(bus.blink_control), 4);
    cyc();
    bus.btn_inc = 1'b1; cyc();
    bus.btn_inc = 1'b0; repeat (3) cyc();
    @(negedge clk);
    chk("post-reset inc_hours", cnt_h - h0, 1);
    chk("post-reset inc_minutes", cnt_m - m0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
